// File: rtl/aes_pkg.sv
// Shared AES arithmetic (S-box, GF(2^8) helpers, MixColumns) and core-level types.
// Byte and word order follow FIPS-197: byte 0 / word 0 sit in the most significant bits.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Entry n lives at bits [2047-8n -: 8], so the table reads left to right like FIPS-197.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [3:0] nr_f(input int key_bits);
        return (key_bits == 128) ? 4'd10 : 4'd14;
    endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Block request / result bundle between the host-side FIFO and aes_iter_core.
interface aes_iter_core_if #(
    parameter int KEY_BITS = 256
);
    // Request: a block transfers on a clock edge where v_i && ready_o; plaintext_i/key_i are
    // sampled only then. Result: ciphertext_o is held while v_o; it is consumed on an edge where
    // yumi_i is high, and yumi_i may only be raised while v_o is already high.
    logic                v_i;
    logic                ready_o;
    logic [127:0]        plaintext_i;
    logic [KEY_BITS-1:0] key_i;
    logic                v_o;
    logic [127:0]        ciphertext_o;
    logic                yumi_i;

    modport master (
        output v_i, plaintext_i, key_i, yumi_i,
        input  ready_o, v_o, ciphertext_o
    );

    modport slave (
        input  v_i, plaintext_i, key_i, yumi_i,
        output ready_o, v_o, ciphertext_o
    );

endinterface

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_round_i,
    output logic [127:0] state_o
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    // State byte (row r, column c) is byte index 4c+r of the 128-bit vector.
    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int n = 0; n < 16; n++) begin
            sb[127-8*n -: 8] = sbox(state_i[127-8*n -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
    end

    assign state_o = (last_round_i ? sr : mc) ^ round_key_i;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryptor: one round per clock, round keys expanded on the fly from an
// Nk-word window, so only the current window (never the full schedule) is stored.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 256
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    aes_iter_core_if.slave   bus,
    output aes_state_e       dbg_state_o
);

    localparam logic [3:0] NR = nr_f(KEY_BITS);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    aes_state_e          fsm_q, fsm_d;
    logic [127:0]        blk_q, blk_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [3:0]          round_q, round_d;
    logic [7:0]          rcon_q, rcon_d;

    logic [127:0]        round_key;
    logic [KEY_BITS-1:0] key_adv;
    logic [7:0]          rcon_adv;
    logic [127:0]        round_out;
    logic                last_round;

    if (KEY_BITS == 128) begin : g_ks128
        // Window holds w[4(r-1)..4r-1]; round r consumes the freshly derived next four words.
        logic [31:0] t, n0, n1, n2, n3;
        assign t         = sub_word(rot_word(key_q[31:0])) ^ {rcon_q, 24'h0};
        assign n0        = key_q[127:96] ^ t;
        assign n1        = key_q[95:64]  ^ n0;
        assign n2        = key_q[63:32]  ^ n1;
        assign n3        = key_q[31:0]   ^ n2;
        assign round_key = {n0, n1, n2, n3};
        assign key_adv   = {n0, n1, n2, n3};
        assign rcon_adv  = xtime(rcon_q);
    end else begin : g_ks256
        // Window holds w[4(r-1)..4r+3]; round r uses its upper half, then slides by four words.
        // The new block starts at i = 4r+4: i mod 8 == 0 for odd r, i mod 8 == 4 for even r.
        logic        odd;
        logic [31:0] t, n0, n1, n2, n3;
        assign odd       = round_q[0];
        assign t         = odd ? (sub_word(rot_word(key_q[31:0])) ^ {rcon_q, 24'h0})
                               : sub_word(key_q[31:0]);
        assign n0        = key_q[255:224] ^ t;
        assign n1        = key_q[223:192] ^ n0;
        assign n2        = key_q[191:160] ^ n1;
        assign n3        = key_q[159:128] ^ n2;
        assign round_key = key_q[127:0];
        assign key_adv   = {key_q[127:0], n0, n1, n2, n3};
        assign rcon_adv  = odd ? xtime(rcon_q) : rcon_q;
    end

    assign last_round = (round_q == NR);

    aes_round u_round (
        .state_i      (blk_q),
        .round_key_i  (round_key),
        .last_round_i (last_round),
        .state_o      (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        blk_d   = blk_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.v_i) begin
                    blk_d   = bus.plaintext_i ^ bus.key_i[KEY_BITS-1 -: 128];
                    key_d   = bus.key_i;
                    round_d = 4'd1;
                    rcon_d  = RCON_INIT;
                    fsm_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                blk_d  = round_out;
                key_d  = key_adv;
                rcon_d = rcon_adv;
                if (last_round) begin
                    fsm_d = ST_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (bus.yumi_i) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fsm_q   <= ST_IDLE;
            blk_q   <= '0;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    assign bus.ready_o      = (fsm_q == ST_IDLE);
    assign bus.v_o          = (fsm_q == ST_DONE);
    assign bus.ciphertext_o = blk_q;
    assign dbg_state_o      = fsm_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 known answers for both key sizes, latency,
// output backpressure, back-to-back spacing and asynchronous reset mid-block.
module tb_aes_iter_core;
  import aes_pkg::*;

  localparam logic [127:0] PT_A     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_A128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT_A128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_A256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_A256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  aes_iter_core_if #(.KEY_BITS(128)) if128 ();
  aes_iter_core_if #(.KEY_BITS(256)) if256 ();
  aes_state_e st128;
  aes_state_e st256;

  aes_iter_core #(.KEY_BITS(128)) dut128 (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .bus         (if128),
    .dbg_state_o (st128)
  );

  aes_iter_core #(.KEY_BITS(256)) dut256 (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .bus         (if256),
    .dbg_state_o (st256)
  );

  // scoreboard
  int n_checks = 0;
  int n_bad = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return '0;
    return exp_q.pop_front();
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic rdy(input bit s);
    return s ? if256.ready_o : if128.ready_o;
  endfunction

  function automatic logic vout(input bit s);
    return s ? if256.v_o : if128.v_o;
  endfunction

  function automatic logic [127:0] ct(input bit s);
    return s ? if256.ciphertext_o : if128.ciphertext_o;
  endfunction

  // driver: the 128-bit core takes the upper half of key
  task automatic drive(input bit s, input logic v, input logic [127:0] pt,
                       input logic [255:0] key, input logic y);
    if (s) begin
      if256.v_i = v; if256.plaintext_i = pt; if256.key_i = key; if256.yumi_i = y;
    end else begin
      if128.v_i = v; if128.plaintext_i = pt; if128.key_i = key[255:128]; if128.yumi_i = y;
    end
  endtask

  // one block with yumi_i tied high; expected ciphertext already queued by the caller
  task automatic run_vec(input string tag, input bit s, input logic [127:0] pt,
                         input logic [255:0] key, input int exp_lat);
    int lat;
    drive(s, 1'b1, pt, key, 1'b1);
    @(negedge clk);
    check({tag, " accepted"}, 128'(rdy(s)), 128'd0);
    drive(s, 1'b0, rnd128(), {rnd128(), rnd128()}, 1'b1);
    lat = 0;
    while (!vout(s) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " ct"}, ct(s), pop_exp());
    @(negedge clk);
    check({tag, " v_o one cycle"}, 128'(vout(s)), 128'd0);
    check({tag, " ready back"}, 128'(rdy(s)), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pts [3];
    logic [255:0] keys [3];
    logic [127:0] cts [3];
    int acc [3];
    int nxt, got, cyc, lat;

    reset_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);

    // reset state
    check("rst ready128", 128'(rdy(1'b0)), 128'd1);
    check("rst v_o128", 128'(vout(1'b0)), 128'd0);
    check("rst ct128", ct(1'b0), 128'd0);
    check("rst state128", 128'(st128), 128'(ST_IDLE));
    check("rst ready256", 128'(rdy(1'b1)), 128'd1);
    check("rst v_o256", 128'(vout(1'b1)), 128'd0);
    check("rst ct256", ct(1'b1), 128'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-rst ready128", 128'(rdy(1'b0)), 128'd1);

    // known-answer vectors
    exp_q.push_back(CT_A128);
    run_vec("c1_128", 1'b0, PT_A, KEY_A128, 10);
    exp_q.push_back(CT_B);
    run_vec("b_128", 1'b0, PT_B, KEY_B128, 10);
    exp_q.push_back(CT_A256);
    run_vec("c3_256", 1'b1, PT_A, KEY_A256, 14);

    // backpressure, with junk on the inputs during BUSY and DONE
    exp_q.push_back(CT_B);
    drive(1'b0, 1'b1, PT_B, KEY_B128, 1'b0);
    @(negedge clk);
    check("bp busy state", 128'(st128), 128'(ST_BUSY));
    lat = 0;
    while (!vout(1'b0) && lat < 40) begin
      drive(1'b0, 1'($urandom_range(0, 1)), rnd128(), {rnd128(), rnd128()},
            1'($urandom_range(0, 1)));
      @(negedge clk);
      lat++;
    end
    drive(1'b0, 1'b1, rnd128(), {rnd128(), rnd128()}, 1'b0);
    check("bp latency", 128'(lat), 128'd10);
    check("bp ct", ct(1'b0), pop_exp());
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), rnd128(), {rnd128(), rnd128()}, 1'b0);
      @(negedge clk);
      check("bp hold ct", ct(1'b0), CT_B);
      check("bp hold v_o", 128'(vout(1'b0)), 128'd1);
      check("bp hold ready", 128'(rdy(1'b0)), 128'd0);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    check("bp yumi v_o", 128'(vout(1'b0)), 128'd0);
    check("bp yumi ready", 128'(rdy(1'b0)), 128'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);

    // back-to-back with v_i held high
    pts[0] = PT_B; keys[0] = KEY_B128; cts[0] = CT_B;
    pts[1] = PT_A; keys[1] = KEY_A128; cts[1] = CT_A128;
    pts[2] = PT_B; keys[2] = KEY_B128; cts[2] = CT_B;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    nxt = 0; got = 0; cyc = 0;
    while (got < 3 && cyc < 100) begin
      if (rdy(1'b0) && nxt < 3) begin
        drive(1'b0, 1'b1, pts[nxt], keys[nxt], 1'b1);
        exp_q.push_back(cts[nxt]);
        acc[nxt] = cyc;
        nxt++;
      end
      if (vout(1'b0)) begin
        check("b2b ct", ct(1'b0), pop_exp());
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    check("b2b results", 128'(got), 128'd3);
    check("b2b gap1", 128'(acc[1] - acc[0]), 128'd12);
    check("b2b gap2", 128'(acc[2] - acc[1]), 128'd12);

    // asynchronous reset at round 5
    drive(1'b0, 1'b1, PT_A, KEY_A128, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    repeat (4) @(negedge clk);
    check("mid busy state", 128'(st128), 128'(ST_BUSY));
    reset_n = 1'b0;
    #1;
    check("async rst v_o", 128'(vout(1'b0)), 128'd0);
    check("async rst ready", 128'(rdy(1'b0)), 128'd1);
    check("async rst ct", ct(1'b0), 128'd0);
    check("async rst state", 128'(st128), 128'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(CT_A128);
    run_vec("post_rst", 1'b0, PT_A, KEY_A128, 10);

    check("exp_q drained", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Iterative, parametrised AES encryption core: one round per clock, key schedule generated on the fly, key length selected at elaboration (AES-128 or AES-256). Successor to the fixed-key-size `aes_encryption` datapath: adds valid/ready input and valid/yumi output handshakes with output backpressure, and stores no full expanded-key chain. Sits between the host request FIFO and the ciphertext return path in `aes_algorithm_chip`.

## Interface
- `KEY_BITS`, 256, key length; legal values 128 and 256 only; elaboration error otherwise
- `clk_i`  in  1  clock
- `reset_n_i`  in  1  asynchronous, active-low reset
- `v_i`  in  1  input block valid
- `ready_o`  out  1  core can accept a block; reset value 1
- `plaintext_i`  in  128  plaintext, FIPS-197 byte order (byte 0 = bits [127:120])
- `key_i`  in  KEY_BITS  cipher key, FIPS-197 byte order
- `v_o`  out  1  ciphertext valid; reset value 0
- `ciphertext_o`  out  128  result; reset value 0; stable while `v_o`=1
- `yumi_i`  in  1  consumer takes result; legal only when `v_o`=1

## Operation
- Nr = 10 (KEY_BITS=128) or 14 (KEY_BITS=256); round counter 4 bits.
- FSM states: IDLE, BUSY, DONE. Reset -> IDLE.
- IDLE: `ready_o`=1, `v_o`=0. On `v_i`&`ready_o`: state <= plaintext_i ^ w[0..3]; key window <= key_i; round <= 1; rcon <= 0x01; -> BUSY.
- BUSY: `ready_o`=0. Each cycle: SubBytes, ShiftRows, MixColumns (omitted when round==Nr), AddRoundKey with w[4r..4r+3]. round increments; at round==Nr -> DONE.
- Key schedule: FIPS-197 expansion, window of Nk words (4 or 8) advanced on the fly; RotWord+SubWord+Rcon on i mod Nk == 0; AES-256 additionally SubWord on i mod 8 == 4. rcon updated by xtime. No stored schedule.
- DONE: `v_o`=1, `ciphertext_o` = state register. On `yumi_i` -> IDLE. Without `yumi_i`, hold indefinitely.
- `plaintext_i`/`key_i` sampled only on the accept edge; changes afterwards have no effect. `v_i` outside IDLE is ignored (not queued).
- `yumi_i` while `v_o`=0: ignored.

## Timing
- `ready_o`, `v_o` decoded from FSM state only (no input-to-output combinational path).
- Accept at edge E0; round r completes at edge Er; `v_o` rises after edge ENr (10 or 14 cycles after accept).
- `yumi_i` at edge Ey -> `ready_o`=1 in the following cycle; next accept earliest at Ey+1. Minimum initiation interval Nr+2 cycles.
- Reset asserted at any point (including mid-BUSY or in DONE): FSM -> IDLE, `v_o`=0, `ciphertext_o`=0, `ready_o`=1 immediately (asynchronous); in-flight block discarded.
- Deassertion is synchronised externally; core tolerates first edge after release as normal edge.

## Structure
- Package `aes_pkg`: S-box table/function, `xtime`, `mix_column` function, Rcon start constant, FSM state enum, `nr_f(KEY_BITS)` function.
- Sub-module `aes_round`: combinational single round (state in, round key in, `last_round` flag in, state out); one instance.
- Key-window update and FSM in `aes_iter_core`.

## Test plan
- KEY_BITS=128, pt 00112233445566778899aabbccddeeff, key 000102…0f, `yumi_i` tied 1 -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, `v_o` high exactly 10 cycles after accept, for 1 cycle.
- KEY_BITS=128, pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32.
- KEY_BITS=256, pt 00112233445566778899aabbccddeeff, key 000102…1f -> 8ea2b7ca516745bfeafc49904b496089, `v_o` 14 cycles after accept.
- Backpressure: hold `yumi_i`=0 for 20 cycles in DONE -> `ciphertext_o` stable, `v_o`=1, `ready_o`=0; randomise `plaintext_i`/`key_i`/`v_i` during BUSY and DONE -> result unchanged.
- Back-to-back: `v_i` held high, `yumi_i` tied 1, three blocks -> accepts spaced exactly Nr+2 cycles, all three ciphertexts correct.
- Reset: assert `reset_n_i` low at round 5 -> `v_o`=0, `ready_o`=1 without waiting for an edge; next block after release encrypts correctly.
